// File: rtl/aes_pkg.sv
// Shared AES-128 helpers: S-boxes, round constants, GF(2^8) arithmetic, word helpers
// and FSM state encoding, used by both the encryptor and the decryptor.
package aes_pkg;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_KEYEXP = 2'd1;
  localparam logic [1:0] S_ROUND  = 2'd2;

  typedef enum logic [1:0] {
    IDLE   = S_IDLE,
    KEYEXP = S_KEYEXP,
    ROUND  = S_ROUND
  } fsm_t;

  // Each table row holds 16 entries for one high nibble; the low nibble picks the byte.
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [127:0] row;
    row = '0;
    case (x[7:4])
      4'h0: row = 128'h637c777bf26b6fc53001672bfed7ab76;
      4'h1: row = 128'hca82c97dfa5947f0add4a2af9ca472c0;
      4'h2: row = 128'hb7fd9326363ff7cc34a5e5f171d83115;
      4'h3: row = 128'h04c723c31896059a071280e2eb27b275;
      4'h4: row = 128'h09832c1a1b6e5aa0523bd6b329e32f84;
      4'h5: row = 128'h53d100ed20fcb15b6acbbe394a4c58cf;
      4'h6: row = 128'hd0efaafb434d338545f9027f503c9fa8;
      4'h7: row = 128'h51a3408f929d38f5bcb6da2110fff3d2;
      4'h8: row = 128'hcd0c13ec5f974417c4a77e3d645d1973;
      4'h9: row = 128'h60814fdc222a908846eeb814de5e0bdb;
      4'ha: row = 128'he0323a0a4906245cc2d3ac629195e479;
      4'hb: row = 128'he7c8376d8dd54ea96c56f4ea657aae08;
      4'hc: row = 128'hba78252e1ca6b4c6e8dd741f4bbd8b8a;
      4'hd: row = 128'h703eb5664803f60e613557b986c11d9e;
      4'he: row = 128'he1f8981169d98e949b1e87e9ce5528df;
      4'hf: row = 128'h8ca1890dbfe6426841992d0fb054bb16;
    endcase
    row = row << {x[3:0], 3'b000};
    return row[127:120];
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] x);
    logic [127:0] row;
    row = '0;
    case (x[7:4])
      4'h0: row = 128'h52096ad53036a538bf40a39e81f3d7fb;
      4'h1: row = 128'h7ce339829b2fff87348e4344c4dee9cb;
      4'h2: row = 128'h547b9432a6c2233dee4c950b42fac34e;
      4'h3: row = 128'h082ea16628d924b2765ba2496d8bd125;
      4'h4: row = 128'h72f8f66486689816d4a45ccc5d65b692;
      4'h5: row = 128'h6c704850fdedb9da5e154657a78d9d84;
      4'h6: row = 128'h90d8ab008cbcd30af7e45805b8b34506;
      4'h7: row = 128'hd02c1e8fca3f0f02c1afbd0301138a6b;
      4'h8: row = 128'h3a9111414f67dcea97f2cfcef0b4e673;
      4'h9: row = 128'h96ac7422e7ad3585e2f937e81c75df6e;
      4'ha: row = 128'h47f11a711d29c5896fb7620eaa18be1b;
      4'hb: row = 128'hfc563e4bc6d279209adbc0fe78cd5af4;
      4'hc: row = 128'h1fdda8338807c731b11210592780ec5f;
      4'hd: row = 128'h60517fa919b54a0d2de57a9f93c99cef;
      4'he: row = 128'ha0e03b4dae2af5b0c8ebbb3c83539961;
      4'hf: row = 128'h172b047eba77d626e169146355210c7d;
    endcase
    row = row << {x[3:0], 3'b000};
    return row[127:120];
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] i);
    case (i)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  // Shift-and-add multiply; with a constant b it collapses to a fixed xtime/xor chain.
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  function automatic logic [31:0] rot_word(input logic [31:0] w);
    return {w[23:0], w[31:24]};
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

endpackage

// File: rtl/aes_inv_round.sv
// One AES inverse round, purely combinational: InvShiftRows, InvSubBytes,
// AddRoundKey, then InvMixColumns unless this is the final round.
module aes_inv_round
  import aes_pkg::*;
(
  input  logic [127:0] state,
  input  logic [127:0] rk,
  input  logic         last,
  output logic [127:0] next_state
);

  logic [127:0] sub_shift;
  logic [127:0] added;
  logic [127:0] mixed;
  logic [7:0]   a0, a1, a2, a3;

  always_comb begin
    sub_shift = '0;
    mixed     = '0;
    a0 = '0; a1 = '0; a2 = '0; a3 = '0;
    // Byte (row r, column c) sits at index 4*c+r; row r rotates right by r columns.
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        sub_shift[127-8*(4*c+r) -: 8] = inv_sbox(state[127-8*(4*((c-r+4)%4)+r) -: 8]);
      end
    end
    added = sub_shift ^ rk;
    for (int c = 0; c < 4; c++) begin
      a0 = added[127-32*c -: 8];
      a1 = added[119-32*c -: 8];
      a2 = added[111-32*c -: 8];
      a3 = added[103-32*c -: 8];
      mixed[127-32*c -: 8] = gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09);
      mixed[119-32*c -: 8] = gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d);
      mixed[111-32*c -: 8] = gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b);
      mixed[103-32*c -: 8] = gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e);
    end
    next_state = last ? added : mixed;
  end

endmodule

// File: rtl/aes_decrypt_top.sv
// Iterative AES-128 decryptor: 10 forward key steps then 10 inverse rounds, done pulses
// 20 cycles after the accepting edge; start is dropped while busy, no queuing.
module aes_decrypt_top
  import aes_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [127:0] datain,
  input  logic [127:0] key,
  output logic [127:0] finalout,
  output logic         busy,
  output logic         done
);

  fsm_t         fsm;
  logic [3:0]   cnt;
  logic [127:0] state;
  logic [127:0] rk;
  logic [127:0] rk_fwd;
  logic [127:0] rk_prev;
  logic [127:0] round_out;

  function automatic logic [127:0] key_step(input logic [127:0] k, input logic [7:0] rc);
    logic [31:0] w0, w1, w2, w3;
    w0 = k[127:96] ^ sub_word(rot_word(k[31:0])) ^ {rc, 24'h0};
    w1 = k[95:64] ^ w0;
    w2 = k[63:32] ^ w1;
    w3 = k[31:0]  ^ w2;
    return {w0, w1, w2, w3};
  endfunction

  // Undo one key step: recover the older words 3..1 first, since word 0 needs old word 3.
  function automatic logic [127:0] key_unstep(input logic [127:0] k, input logic [7:0] rc);
    logic [31:0] w0, w1, w2, w3;
    w3 = k[31:0]  ^ k[63:32];
    w2 = k[63:32] ^ k[95:64];
    w1 = k[95:64] ^ k[127:96];
    w0 = k[127:96] ^ sub_word(rot_word(w3)) ^ {rc, 24'h0};
    return {w0, w1, w2, w3};
  endfunction

  assign rk_fwd  = key_step(rk, rcon(cnt));
  assign rk_prev = key_unstep(rk, rcon(cnt + 4'd1));

  aes_inv_round u_inv_round (
    .state      (state),
    .rk         (rk_prev),
    .last       (cnt == 4'd0),
    .next_state (round_out)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fsm      <= IDLE;
      cnt      <= '0;
      state    <= '0;
      rk       <= '0;
      finalout <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (fsm)
        IDLE: begin
          if (start) begin
            state <= datain;
            rk    <= key;
            cnt   <= 4'd1;
            busy  <= 1'b1;
            fsm   <= KEYEXP;
          end
        end
        KEYEXP: begin
          rk <= rk_fwd;
          if (cnt == 4'd10) begin
            state <= state ^ rk_fwd;
            cnt   <= 4'd9;
            fsm   <= ROUND;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        ROUND: begin
          state <= round_out;
          rk    <= rk_prev;
          if (cnt == 4'd0) begin
            finalout <= round_out;
            done     <= 1'b1;
            busy     <= 1'b0;
            fsm      <= IDLE;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        default: fsm <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/aes_decrypt_top.md
# aes_decrypt_top

Iterative AES-128 decryptor, the inverse-cipher counterpart of the encryption top. It accepts a 128-bit ciphertext and cipher key on a start strobe, derives the final round key on the fly, and runs ten inverse rounds at one round per clock. It returns the plaintext on a registered output qualified by a one-cycle done pulse. It sits beside the encryptor and shares its S-box and key-schedule helpers.

## Interface
- No parameters. AES-128 only: Nk=4, Nr=10.
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  request strobe; sampled only while busy=0.
- datain  in  128  ciphertext; byte 0 is in [127:120], FIPS-197 column-major order.
- key  in  128  cipher key, same byte order; sampled together with datain.
- finalout  out  128  plaintext, registered; reset value 0.
- busy  out  1  high while an operation is in progress; reset value 0.
- done  out  1  one-cycle pulse when finalout is updated; reset value 0.

## Operation
- FSM states:
  - IDLE: wait for start. If start=1, capture datain into the state register and key into the round-key register, set cnt=1, go to KEYEXP.
  - KEYEXP: forward key expansion, one step per cycle. rk <= expand(rk, rcon[cnt]), cnt++.
    - On the cnt=10 cycle, also state <= state ^ expand(rk, rcon[10]), i.e. the initial AddRoundKey with rk10. Then set cnt=9 and go to ROUND.
  - ROUND: rk holds rk(cnt+1).
    - Combinationally derive rk(cnt) = inverse_expand(rk(cnt+1), rcon[cnt+1]), using w[i-4] = w[i] ^ w[i-1] for words 1..3, and word 0 = w[4] ^ SubWord(RotWord(w'[3])) ^ rcon.
    - state <= InvMixColumns(InvSubBytes(InvShiftRows(state)) ^ rk(cnt)); InvMixColumns is omitted when cnt=0.
    - rk <= rk(cnt). If cnt=0, go to DONE; else cnt--.
  - DONE: not a held state. On the cnt=0 ROUND edge, finalout <= round result, done <= 1, busy <= 0, and the FSM returns to IDLE.
- busy=1 in KEYEXP and ROUND. start is ignored while busy=1. There is no queuing and no error flag.
- datain and key are sampled only on the accepting edge and may change afterwards without effect.
- finalout holds its value until the next done. It is not cleared at start.
- Arithmetic is GF(2^8) with polynomial 0x11B. InvMixColumns uses multipliers {0e,0b,0d,09} built from xtime chains.

## Timing
- Edge E0 accepts start. E1–E10 run KEYEXP. E11–E20 run ROUND (cnt 9..0).
- After E20, finalout is valid and done=1 for exactly one cycle, the 20th cycle after the accepting edge. busy is high from after E0 through E20.
- Throughput: one block per 21 cycles. A start asserted during the done cycle is accepted, giving back-to-back blocks every 21 cycles.
- A start pulse while busy is dropped. It is not latched for later.
- rst asserted at any time, including mid-KEYEXP or mid-ROUND, immediately forces IDLE, cnt=0, state=0, rk=0, finalout=0, busy=0, done=0. The in-flight block is lost. The first start after rst deasserts is accepted normally.
- No combinational path from inputs to outputs.

## Structure
- Shared package aes_pkg:
  - sbox and inv_sbox functions (256-entry case);
  - rcon function indexed 1..10;
  - xtime and gmul helpers;
  - the SubWord/RotWord helpers, shared with the encryptor;
  - state encoding localparams for IDLE/KEYEXP/ROUND.
- Sub-module aes_inv_round: purely combinational, inputs state[127:0], rk[127:0], last; output next_state[127:0]. It performs InvShiftRows → InvSubBytes → AddRoundKey → InvMixColumns (skipped when last=1).
- The top holds the FSM, counter, state/rk registers, the forward and inverse key-step logic, and the output register.

## Test plan
- FIPS-197 C.1: key 000102030405060708090a0b0c0d0e0f, datain 69c4e0d86a7b0430d8cdb78070b4c55a → finalout 00112233445566778899aabbccddeeff with done exactly 20 cycles after the accepting edge. Internal rk after E10 = 13111d7fe3944a17f307a78b4d2b30c5.
- FIPS-197 App. B: key 2b7e151628aed2a6abf7158809cf4f3c, datain 3925841d02dc09fbdc118597196a0b32 → 3243f6a8885a308d313198a2e0370734. rk after E10 = d014f9a8c9ee2589e13f0cc8b6630ca6.
- Start held high continuously with alternating C.1 and App. B vectors → one done every 21 cycles with the correct plaintexts in order. Extra start pulses during busy produce no extra done.
- rst pulsed at cycle 7 of a C.1 run → all outputs 0 immediately. A new App. B start afterwards gives the correct result at +20 cycles, and no stale done appears.
- Loopback: encryptor output for 200 random key/plaintext pairs fed to the decryptor → finalout equals the original plaintext every time; busy/done protocol checked by assertion.
